// File: rtl/logiana_trig_cap.sv
// Logic-analyser capture controller: divided-rate probe sampling into a ring-addressed
// sample RAM, per-channel level/edge trigger, guaranteed pre-trigger history, post-trigger length.
module logiana_trig_cap #(
   parameter int CH = 32,
   parameter int AW = 17
) (
   input  logic          OSC_CLK,
   input  logic          RST,
   input  logic [CH-1:0] PROBE,
   input  logic          START,
   input  logic          STOP,
   input  logic [7:0]    CFG_DIV,
   input  logic [CH-1:0] TRIG_MASK,
   input  logic [CH-1:0] TRIG_VAL,
   input  logic [CH-1:0] TRIG_EDGE,
   input  logic [AW-1:0] PRE_CNT,
   input  logic [AW-1:0] POST_CNT,
   output logic [AW-1:0] RAM_ADDR,
   output logic [CH-1:0] RAM_WDATA,
   output logic          RAM_WE,
   output logic          RUNNING,
   output logic          TRIGGERED,
   output logic          DONE,
   output logic [AW-1:0] TRIG_ADDR,
   output logic [AW-1:0] START_ADDR
);

   typedef enum logic [2:0] {S_IDLE, S_PRE, S_ARMED, S_POST, S_DONE} state_t;

   state_t        state_reg, state_next;
   logic [7:0]    div_cfg_reg, div_cfg_next;
   logic [CH-1:0] mask_reg, mask_next;
   logic [CH-1:0] val_reg, val_next;
   logic [CH-1:0] edge_sel_reg, edge_sel_next;
   logic [AW-1:0] pre_reg, pre_next;
   logic [AW-1:0] post_reg, post_next;
   logic [7:0]    div_cnt_reg, div_cnt_next;
   logic [AW-1:0] cnt_reg, cnt_next;
   logic [AW-1:0] ptr_reg, ptr_next;
   logic [CH-1:0] prev_reg, prev_next;
   logic          prev_valid_reg, prev_valid_next;
   logic [AW-1:0] addr_reg, addr_next;
   logic [CH-1:0] wdata_reg, wdata_next;
   logic          we_reg, we_next;
   logic          triggered_reg, triggered_next;
   logic          done_reg, done_next;
   logic [AW-1:0] trig_addr_reg, trig_addr_next;
   logic [AW-1:0] start_addr_reg, start_addr_next;

   logic [CH-1:0] term;
   logic [AW-1:0] cnt_inc;
   logic          running, tick, start_ok, trig_hit;

   // Unmasked channels contribute a constant 1 so an all-zero mask fires on the first eligible sample.
   genvar gi;
   generate
      for (gi = 0; gi < CH; gi++) begin : g_term
         logic match;
         assign match    = (PROBE[gi] == val_reg[gi]);
         assign term[gi] = ~mask_reg[gi] |
                           (edge_sel_reg[gi] ? (prev_valid_reg & (prev_reg[gi] != val_reg[gi]) & match)
                                             : match);
      end
   endgenerate

   assign trig_hit = &term;
   assign running  = (state_reg == S_PRE) || (state_reg == S_ARMED) || (state_reg == S_POST);
   assign tick     = running && (div_cnt_reg == 8'd0);
   assign start_ok = START && ((state_reg == S_IDLE) || (state_reg == S_DONE));
   assign cnt_inc  = cnt_reg + AW'(1);

   always_comb begin
      state_next      = state_reg;
      div_cfg_next    = div_cfg_reg;
      mask_next       = mask_reg;
      val_next        = val_reg;
      edge_sel_next   = edge_sel_reg;
      pre_next        = pre_reg;
      post_next       = post_reg;
      div_cnt_next    = div_cnt_reg;
      cnt_next        = cnt_reg;
      ptr_next        = ptr_reg;
      prev_next       = prev_reg;
      prev_valid_next = prev_valid_reg;
      addr_next       = addr_reg;
      wdata_next      = wdata_reg;
      we_next         = 1'b0;
      triggered_next  = triggered_reg;
      trig_addr_next  = trig_addr_reg;
      start_addr_next = start_addr_reg;

      if (running && STOP) begin
         state_next     = S_IDLE;
         triggered_next = 1'b0;
      end else if (start_ok) begin
         div_cfg_next    = CFG_DIV;
         mask_next       = TRIG_MASK;
         val_next        = TRIG_VAL;
         edge_sel_next   = TRIG_EDGE;
         pre_next        = PRE_CNT;
         post_next       = POST_CNT;
         div_cnt_next    = 8'd0;
         cnt_next        = '0;
         ptr_next        = '0;
         prev_valid_next = 1'b0;
         triggered_next  = 1'b0;
         state_next      = (PRE_CNT != '0) ? S_PRE : S_ARMED;
      end else if (running) begin
         div_cnt_next = (div_cnt_reg == div_cfg_reg) ? 8'd0 : div_cnt_reg + 8'd1;
         if (tick) begin
            wdata_next      = PROBE;
            addr_next       = ptr_reg;
            we_next         = 1'b1;
            ptr_next        = ptr_reg + AW'(1);
            prev_next       = PROBE;
            prev_valid_next = 1'b1;
            case (state_reg)
               S_PRE: begin
                  if (cnt_inc == pre_reg) begin
                     state_next = S_ARMED;
                     cnt_next   = '0;
                  end else begin
                     cnt_next = cnt_inc;
                  end
               end
               S_ARMED: begin
                  if (trig_hit) begin
                     trig_addr_next  = ptr_reg;
                     start_addr_next = ptr_reg - pre_reg;
                     triggered_next  = 1'b1;
                     cnt_next        = '0;
                     state_next      = (post_reg == '0) ? S_DONE : S_POST;
                  end
               end
               S_POST: begin
                  if (cnt_inc == post_reg) begin
                     state_next = S_DONE;
                  end else begin
                     cnt_next = cnt_inc;
                  end
               end
               default: ;
            endcase
         end
      end

      // Registered one cycle behind the state so DONE follows the final write strobe.
      done_next = (state_reg == S_DONE) && !start_ok;
   end

   always_ff @(posedge OSC_CLK) begin
      if (RST) begin
         state_reg      <= S_IDLE;
         div_cfg_reg    <= '0;
         mask_reg       <= '0;
         val_reg        <= '0;
         edge_sel_reg   <= '0;
         pre_reg        <= '0;
         post_reg       <= '0;
         div_cnt_reg    <= '0;
         cnt_reg        <= '0;
         ptr_reg        <= '0;
         prev_reg       <= '0;
         prev_valid_reg <= 1'b0;
         addr_reg       <= '0;
         wdata_reg      <= '0;
         we_reg         <= 1'b0;
         triggered_reg  <= 1'b0;
         done_reg       <= 1'b0;
         trig_addr_reg  <= '0;
         start_addr_reg <= '0;
      end else begin
         state_reg      <= state_next;
         div_cfg_reg    <= div_cfg_next;
         mask_reg       <= mask_next;
         val_reg        <= val_next;
         edge_sel_reg   <= edge_sel_next;
         pre_reg        <= pre_next;
         post_reg       <= post_next;
         div_cnt_reg    <= div_cnt_next;
         cnt_reg        <= cnt_next;
         ptr_reg        <= ptr_next;
         prev_reg       <= prev_next;
         prev_valid_reg <= prev_valid_next;
         addr_reg       <= addr_next;
         wdata_reg      <= wdata_next;
         we_reg         <= we_next;
         triggered_reg  <= triggered_next;
         done_reg       <= done_next;
         trig_addr_reg  <= trig_addr_next;
         start_addr_reg <= start_addr_next;
      end
   end

   assign RAM_ADDR   = addr_reg;
   assign RAM_WDATA  = wdata_reg;
   assign RAM_WE     = we_reg;
   assign RUNNING    = running;
   assign TRIGGERED  = triggered_reg;
   assign DONE       = done_reg;
   assign TRIG_ADDR  = trig_addr_reg;
   assign START_ADDR = start_addr_reg;

endmodule

// File: tb/tb_logiana_trig_cap.sv
// Bench for logiana_trig_cap: directed and random captures compared cycle by cycle
// against a sample-level model of the capture/trigger rules.
module tb_logiana_trig_cap;
   localparam int CH    = 8;
   localparam int AW    = 4;
   localparam int DEPTH = 16;
   localparam int LIM   = 200;
   localparam int NPC   = 512;
   localparam int INF   = 1 << 30;

   logic          clk = 1'b0;
   logic          rst, start, stop;
   logic [CH-1:0] probe, mask, val, edg;
   logic [7:0]    div;
   logic [AW-1:0] pre, post;
   logic [AW-1:0] ram_addr, trig_addr, start_addr;
   logic [CH-1:0] ram_wdata;
   logic          ram_we, running, triggered, done;

   int errors = 0;
   int checks = 0;
   logic [CH-1:0] pc [NPC];

   always #5 clk = ~clk;

   logiana_trig_cap #(.CH(CH), .AW(AW)) dut (
      .OSC_CLK(clk), .RST(rst), .PROBE(probe), .START(start), .STOP(stop),
      .CFG_DIV(div), .TRIG_MASK(mask), .TRIG_VAL(val), .TRIG_EDGE(edg),
      .PRE_CNT(pre), .POST_CNT(post),
      .RAM_ADDR(ram_addr), .RAM_WDATA(ram_wdata), .RAM_WE(ram_we),
      .RUNNING(running), .TRIGGERED(triggered), .DONE(done),
      .TRIG_ADDR(trig_addr), .START_ADDR(start_addr)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h at %0t", tag, obs, expv, $time);
      end
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, " ram_addr"},   32'(ram_addr),   32'd0);
      chk({tag, " ram_wdata"},  32'(ram_wdata),  32'd0);
      chk({tag, " ram_we"},     32'(ram_we),     32'd0);
      chk({tag, " running"},    32'(running),    32'd0);
      chk({tag, " triggered"},  32'(triggered),  32'd0);
      chk({tag, " done"},       32'(done),       32'd0);
      chk({tag, " trig_addr"},  32'(trig_addr),  32'd0);
      chk({tag, " start_addr"}, 32'(start_addr), 32'd0);
   endtask

   task automatic fill_rand();
      for (int c = 0; c < NPC; c++) pc[c] = CH'($urandom);
   endtask

   // pc[c] is the PROBE value presented during cycle c; cycle 0 carries the START pulse.
   task automatic capture(input string name, input logic [7:0] d, input logic [CH-1:0] m,
                          input logic [CH-1:0] v, input logic [CH-1:0] e,
                          input logic [AW-1:0] p, input logic [AW-1:0] q,
                          input int stop_c, input bit stop_start, input int start2_c, input int rst_c);
      logic [CH-1:0] smp [NPC];
      int per, nsmp, t, nw, stop_lim, ncyc, tr_c, done_c, n, writes;
      bit hit, exp_we, exp_tr, exp_dn, exp_rn;
      per  = int'(d) + 1;
      nsmp = 0;
      while (1 + nsmp * per < LIM) begin
         smp[nsmp] = pc[1 + nsmp * per];
         nsmp++;
      end
      t = -1;
      for (int k = int'(p); k < nsmp && t < 0; k++) begin
         hit = 1'b1;
         for (int i = 0; i < CH; i++) begin
            if (m[i]) begin
               if (e[i]) begin
                  if (!(k > 0 && smp[k-1][i] != v[i] && smp[k][i] == v[i])) hit = 1'b0;
               end else if (smp[k][i] != v[i]) begin
                  hit = 1'b0;
               end
            end
         end
         if (hit) t = k;
      end
      nw     = (t >= 0) ? t + int'(q) + 1 : INF;
      tr_c   = 2 + t * per;
      done_c = 3 + (t + int'(q)) * per;
      stop_lim = INF;
      if (stop_c >= 0) stop_lim = stop_c;
      if (rst_c >= 0 && rst_c < stop_lim) stop_lim = rst_c;
      if (t < 0 && stop_lim == INF) begin
         stop_c   = LIM;
         stop_lim = LIM;
      end
      if (start2_c >= 0 && !(start2_c >= 1 && ((t < 0) ? start2_c <= stop_lim : start2_c < done_c - 1)))
         start2_c = -1;
      if (rst_c >= 0)       ncyc = rst_c + 2;
      else if (stop_c >= 0) ncyc = stop_c + 6;
      else                  ncyc = done_c + 4;

      div = d; mask = m; val = v; edg = e; pre = p; post = q;
      start = 1'b1; stop = 1'b0; rst = 1'b0; probe = pc[0];
      writes = 0;
      for (int c = 1; c <= ncyc; c++) begin
         @(posedge clk); #1;
         if (rst_c >= 0 && c > rst_c) begin
            chk_zero("after_rst");
         end else begin
            exp_we = 1'b0;
            n = 0;
            if (c >= 2 && (c - 2) % per == 0) begin
               n = (c - 2) / per;
               exp_we = (n < nw) && (c <= stop_lim);
            end
            chk("ram_we", 32'(ram_we), 32'(exp_we));
            if (exp_we) begin
               chk("ram_addr", 32'(ram_addr), 32'(n % DEPTH));
               chk("ram_wdata", 32'(ram_wdata), 32'(pc[1 + n * per]));
               writes++;
            end
            exp_tr = (t >= 0) && (c >= tr_c) && (c <= stop_lim);
            exp_dn = (t >= 0) && (c >= done_c) && (c <= stop_lim);
            exp_rn = (c <= stop_lim) && (t < 0 || c < done_c - 1);
            chk("triggered", 32'(triggered), 32'(exp_tr));
            chk("done", 32'(done), 32'(exp_dn));
            chk("running", 32'(running), 32'(exp_rn));
            if (exp_tr) begin
               chk("trig_addr", 32'(trig_addr), 32'(t % DEPTH));
               chk("start_addr", 32'(start_addr), 32'((((t - int'(p)) % DEPTH) + DEPTH) % DEPTH));
            end
         end
         // Configuration inputs are scrambled after START; the capture must not see them.
         start = 1'b0; stop = 1'b0; rst = 1'b0; probe = pc[c];
         div = 8'($urandom); mask = CH'($urandom); val = CH'($urandom); edg = CH'($urandom);
         pre = AW'($urandom); post = AW'($urandom);
         if (c == stop_c) begin
            stop  = 1'b1;
            start = stop_start;
         end
         if (c == start2_c) start = 1'b1;
         if (c == rst_c) rst = 1'b1;
      end
      start = 1'b0; stop = 1'b0; rst = 1'b0;
      $display("capture %s: div=%0d pre=%0d post=%0d trig_sample=%0d writes=%0d",
               name, d, p, q, t, writes);
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; stop = 1'b0; probe = '0; div = '0;
      mask = '0; val = '0; edg = '0; pre = '0; post = '0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk_zero("reset");
      rst = 1'b0; probe = '1; stop = 1'b1;
      @(posedge clk); #1;
      chk_zero("idle_stop");
      stop = 1'b0;

      // Rising edge on channel 0 at sample 10, second START in POST must be ignored.
      fill_rand();
      for (int c = 0; c < NPC; c++) pc[c][0] = (c >= 11);
      capture("edge_rise", 8'd0, 8'h01, 8'h01, 8'h01, 4'd3, 4'd4, -1, 1'b0, 13, -1);

      // Divided rate with an empty mask: trigger on the first eligible sample.
      fill_rand();
      capture("div3", 8'd3, 8'h00, 8'h00, 8'h00, 4'd5, 4'd3, -1, 1'b0, -1, -1);

      // Channel 0 held high: edge mode never fires, level mode fires at sample PRE_CNT.
      fill_rand();
      for (int c = 0; c < NPC; c++) pc[c][0] = 1'b1;
      capture("edge_held", 8'd0, 8'h01, 8'h01, 8'h01, 4'd2, 4'd3, -1, 1'b0, -1, -1);
      capture("level_held", 8'd0, 8'h01, 8'h01, 8'h00, 4'd2, 4'd3, -1, 1'b0, -1, -1);

      // Ring wrap: trigger at sample 20 lands on address 4.
      fill_rand();
      for (int c = 0; c < NPC; c++) pc[c][0] = (c >= 21);
      capture("wrap", 8'd0, 8'h01, 8'h01, 8'h00, 4'd2, 4'd3, -1, 1'b0, -1, -1);

      // STOP in ARMED together with START, then a normal capture.
      fill_rand();
      for (int c = 0; c < NPC; c++) pc[c][0] = 1'b0;
      capture("stop_start", 8'd0, 8'h01, 8'h01, 8'h00, 4'd1, 4'd2, 20, 1'b1, -1, -1);
      fill_rand();
      capture("after_stop", 8'd1, 8'h00, 8'h00, 8'h00, 4'd2, 4'd2, -1, 1'b0, -1, -1);

      // Reset during POST.
      fill_rand();
      capture("rst_post", 8'd0, 8'h00, 8'h00, 8'h00, 4'd2, 4'd10, -1, 1'b0, -1, 8);

      for (int r = 0; r < 12; r++) begin
         fill_rand();
         capture("random", 8'($urandom_range(0, 3)), CH'($urandom & $urandom & $urandom),
                 CH'($urandom), CH'($urandom), AW'($urandom_range(0, 15)),
                 AW'($urandom_range(0, 15)), -1, 1'b0, int'($urandom_range(2, 40)), -1);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
